// File: rtl/alu_sequencer.sv
// Command sequencer for the matrix ALU: fetches operands, runs the ALU, writes the result back.
// Build option ALU_TIMEOUT_EN aborts EXEC after TIMEOUT_CYCLES cycles without alu_done.
module alu_sequencer #(
  parameter int AW             = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [3:0]    instr_opcode,
  input  logic [AW-1:0] instr_addr_a,
  input  logic [AW-1:0] instr_addr_b,
  input  logic [AW-1:0] instr_addr_r,
  input  logic [7:0]    instr_scalar,
  output logic [AW-1:0] mem_addr,
  output logic          mem_rd,
  output logic          mem_wr,
  output logic [199:0]  mem_wdata,
  input  logic [199:0]  mem_rdata,
  output logic [3:0]    alu_opcode,
  output logic [7:0]    alu_scalar,
  output logic [199:0]  alu_matriz_a,
  output logic [199:0]  alu_matriz_b,
  output logic          alu_start,
  input  logic [199:0]  alu_result,
  input  logic          alu_done,
  output logic          busy,
  output logic          cmd_done,
  output logic          cmd_error,
  output logic [1:0]    error_code
);

  // state | meaning
  // IDLE  | waiting for a command, instr_ready high
  // RD_A  | read strobe for matrix A
  // RD_B  | capture A, read strobe for matrix B (binary ops)
  // CAP_B | capture B (binary) or A (unary)
  // EXEC  | alu_start held until alu_done (or timeout)
  // WR    | single write of the result register
  // FIN   | cmd_done pulse, back to IDLE
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RD_A  = 3'd1;
  localparam logic [2:0] S_RD_B  = 3'd2;
  localparam logic [2:0] S_CAP_B = 3'd3;
  localparam logic [2:0] S_EXEC  = 3'd4;
  localparam logic [2:0] S_WR    = 3'd5;
  localparam logic [2:0] S_FIN   = 3'd6;

  logic [2:0]    state;
  logic [3:0]    opcode_q;
  logic [7:0]    scalar_q;
  logic [AW-1:0] addr_a_q;
  logic [AW-1:0] addr_b_q;
  logic [AW-1:0] addr_r_q;
  logic [199:0]  mat_a_q;
  logic [199:0]  mat_b_q;
  logic [199:0]  result_q;
  logic [1:0]    err_q;
  logic          exec_first;
  logic          op_legal;
  logic          op_binary;
  logic          tmo_hit;

  assign op_legal  = (instr_opcode >= 4'd3) && (instr_opcode <= 4'd12);
  assign op_binary = (opcode_q <= 4'd5);

`ifdef ALU_TIMEOUT_EN
  // down-counter loaded on entry to EXEC; terminal count ends the wait
  logic [15:0] tmo_cnt;
  assign tmo_hit = (tmo_cnt == 16'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt <= '0;
    end else if (state == S_CAP_B) begin
      tmo_cnt <= 16'(TIMEOUT_CYCLES - 1);
    end else if (state == S_EXEC && !tmo_hit) begin
      tmo_cnt <= tmo_cnt - 16'd1;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      opcode_q   <= '0;
      scalar_q   <= '0;
      addr_a_q   <= '0;
      addr_b_q   <= '0;
      addr_r_q   <= '0;
      mat_a_q    <= '0;
      mat_b_q    <= '0;
      result_q   <= '0;
      err_q      <= '0;
      exec_first <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (instr_valid) begin
            opcode_q <= instr_opcode;
            scalar_q <= instr_scalar;
            addr_a_q <= instr_addr_a;
            addr_b_q <= instr_addr_b;
            addr_r_q <= instr_addr_r;
            mat_b_q  <= '0;
            if (op_legal) begin
              err_q <= 2'b00;
              state <= S_RD_A;
            end else begin
              err_q <= 2'b01;
              state <= S_FIN;
            end
          end
        end
        S_RD_A:  state <= op_binary ? S_RD_B : S_CAP_B;
        S_RD_B: begin
          mat_a_q <= mem_rdata;
          state   <= S_CAP_B;
        end
        S_CAP_B: begin
          if (op_binary) mat_b_q <= mem_rdata;
          else           mat_a_q <= mem_rdata;
          exec_first <= 1'b1;
          state      <= S_EXEC;
        end
        S_EXEC: begin
          exec_first <= 1'b0;
          // a done in the same cycle as the timeout still wins
          if (!exec_first && alu_done) begin
            result_q <= alu_result;
            state    <= S_WR;
          end else if (tmo_hit) begin
            err_q <= 2'b10;
            state <= S_FIN;
          end
        end
        S_WR:    state <= S_FIN;
        S_FIN:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    alu_start = 1'b0;
    case (state)
      S_RD_A: begin
        mem_rd   = 1'b1;
        mem_addr = addr_a_q;
      end
      S_RD_B: begin
        mem_rd   = 1'b1;
        mem_addr = addr_b_q;
      end
      S_EXEC:  alu_start = 1'b1;
      S_WR: begin
        mem_wr   = 1'b1;
        mem_addr = addr_r_q;
      end
      default: ;
    endcase
  end

  assign mem_wdata    = result_q;
  assign alu_opcode   = opcode_q;
  assign alu_scalar   = scalar_q;
  assign alu_matriz_a = mat_a_q;
  assign alu_matriz_b = mat_b_q;
  assign instr_ready  = (state == S_IDLE);
  assign busy         = (state != S_IDLE);
  assign cmd_done     = (state == S_FIN);
  assign cmd_error    = (state == S_FIN) && (err_q != 2'b00);
  assign error_code   = err_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: memory and ALU models, write scoreboard, one task per scenario.
module tb_alu_sequencer;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          instr_valid;
  logic          instr_ready;
  logic [3:0]    instr_opcode;
  logic [AW-1:0] instr_addr_a;
  logic [AW-1:0] instr_addr_b;
  logic [AW-1:0] instr_addr_r;
  logic [7:0]    instr_scalar;
  logic [AW-1:0] mem_addr;
  logic          mem_rd;
  logic          mem_wr;
  logic [199:0]  mem_wdata;
  logic [199:0]  mem_rdata = '0;
  logic [3:0]    alu_opcode;
  logic [7:0]    alu_scalar;
  logic [199:0]  alu_matriz_a;
  logic [199:0]  alu_matriz_b;
  logic          alu_start;
  logic [199:0]  alu_result = '0;
  logic          alu_done = 1'b0;
  logic          busy;
  logic          cmd_done;
  logic          cmd_error;
  logic [1:0]    error_code;

  always #5 clk = ~clk;

  alu_sequencer #(.AW(AW), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_opcode(instr_opcode),
    .instr_addr_a(instr_addr_a), .instr_addr_b(instr_addr_b), .instr_addr_r(instr_addr_r),
    .instr_scalar(instr_scalar),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .alu_opcode(alu_opcode), .alu_scalar(alu_scalar), .alu_matriz_a(alu_matriz_a),
    .alu_matriz_b(alu_matriz_b), .alu_start(alu_start), .alu_result(alu_result),
    .alu_done(alu_done),
    .busy(busy), .cmd_done(cmd_done), .cmd_error(cmd_error), .error_code(error_code)
  );

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;
  int alu_delay = 1;
  int exec_cnt = 0;

  logic [199:0]  mem [0:255];
  logic [199:0]  rd_nxt = '0;
  bit            rd_pend = 1'b0;
  logic [AW-1:0] rd_log[$];
  logic [AW-1:0] wr_addr_log[$];
  logic [199:0]  wr_data_log[$];
  logic [AW-1:0] exp_addr_q[$];
  logic [199:0]  exp_data_q[$];
  int both_cnt = 0, start_cyc = 0, unstable_cnt = 0, b_nonzero = 0, start_at_wr = 0;
  logic          prev_start = 1'b0;
  logic [411:0]  prev_bus = '0;

  int last_lat, last_acc_cyc, last_done_cyc;
  bit last_to, last_err;

  // environment ALU: soma, subtracao, otherwise bytewise oposta of A
  function automatic logic [199:0] alu_fn(input logic [3:0] op, input logic [199:0] a,
                                          input logic [199:0] b);
    logic [199:0] r;
    r = '0;
    for (int i = 0; i < 25; i++) begin
      case (op)
        4'd3:    r[i*8 +: 8] = a[i*8 +: 8] + b[i*8 +: 8];
        4'd4:    r[i*8 +: 8] = a[i*8 +: 8] - b[i*8 +: 8];
        default: r[i*8 +: 8] = 8'd0 - a[i*8 +: 8];
      endcase
    end
    return r;
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rd_pend) mem_rdata <= rd_nxt;
  end

  always @(negedge clk) begin
    if (mem_rd) begin
      rd_log.push_back(mem_addr);
      rd_nxt  = mem[mem_addr];
      rd_pend = 1'b1;
    end else begin
      rd_pend = 1'b0;
    end
    if (mem_wr) begin
      wr_addr_log.push_back(mem_addr);
      wr_data_log.push_back(mem_wdata);
      if (alu_start) start_at_wr++;
    end
    if (mem_rd && mem_wr) both_cnt++;
    if (alu_start) begin
      start_cyc++;
      exec_cnt++;
      alu_done   = (exec_cnt > alu_delay);
      alu_result = alu_fn(alu_opcode, alu_matriz_a, alu_matriz_b);
      if (alu_matriz_b != '0) b_nonzero++;
      if (prev_start && {alu_opcode, alu_scalar, alu_matriz_a, alu_matriz_b} != prev_bus)
        unstable_cnt++;
    end else begin
      exec_cnt = 0;
      alu_done = 1'b0;
    end
    prev_start = alu_start;
    prev_bus   = {alu_opcode, alu_scalar, alu_matriz_a, alu_matriz_b};
  end

  // drives one command and waits (bounded) for its cmd_done; latency counts edges after accept
  task automatic run_cmd(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] r, input logic [7:0] sc);
    int n;
    last_to = 1'b0;
    last_err = 1'b0;
    @(negedge clk);
    instr_valid = 1'b1; instr_opcode = op; instr_addr_a = a;
    instr_addr_b = b; instr_addr_r = r; instr_scalar = sc;
    n = 0;
    while (!instr_ready && n < 200) begin @(negedge clk); n++; end
    last_acc_cyc = cyc;
    @(negedge clk);
    instr_valid = 1'b0;
    last_lat = 0;
    while (!cmd_done && last_lat < 2000) begin @(negedge clk); last_lat++; end
    if (!cmd_done) last_to = 1'b1;
    last_err = cmd_error;
    last_done_cyc = cyc;
  endtask

  task automatic test_reset;
    rst = 1'b1; instr_valid = 1'b0; instr_opcode = '0; instr_addr_a = '0;
    instr_addr_b = '0; instr_addr_r = '0; instr_scalar = '0;
    repeat (3) @(negedge clk);
    total_cnt++;
    if (instr_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", instr_ready);
    else pass_cnt++;
    total_cnt++;
    if ({busy, cmd_done, cmd_error, error_code, mem_rd, mem_wr, alu_start} !== 8'd0)
      $display("FAIL reset_ctrl: got %b want 00000000",
               {busy, cmd_done, cmd_error, error_code, mem_rd, mem_wr, alu_start});
    else pass_cnt++;
    total_cnt++;
    if ({mem_addr, alu_opcode, alu_scalar} !== '0)
      $display("FAIL reset_fields: got %h want 0", {mem_addr, alu_opcode, alu_scalar});
    else pass_cnt++;
    total_cnt++;
    if ({mem_wdata, alu_matriz_a, alu_matriz_b} !== '0)
      $display("FAIL reset_data: operand/result registers not cleared");
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_soma;
    int rb, wb;
    logic [AW-1:0] ea;
    logic [199:0] ed;
    rb = rd_log.size(); wb = wr_addr_log.size();
    alu_delay = 1;
    exp_addr_q.push_back(8'h10); exp_data_q.push_back({25{8'h05}});
    run_cmd(4'd3, 8'h01, 8'h02, 8'h10, 8'h00);
    total_cnt++;
    if (last_to || last_lat != 6) $display("FAIL soma_latency: got %0d (timeout %0b) want 6", last_lat, last_to);
    else pass_cnt++;
    total_cnt++;
    if (rd_log.size() - rb != 2 || rd_log[rb] !== 8'h01 || rd_log[rb+1] !== 8'h02)
      $display("FAIL soma_reads: got %0d reads want 2 at 01,02", rd_log.size() - rb);
    else pass_cnt++;
    total_cnt++;
    ea = exp_addr_q.pop_front(); ed = exp_data_q.pop_front();
    if (wr_addr_log.size() - wb != 1 || wr_addr_log[wb] !== ea || wr_data_log[wb] !== ed)
      $display("FAIL soma_write: got %0d writes want 1 at %h data %h", wr_addr_log.size() - wb, ea, ed);
    else pass_cnt++;
    total_cnt++;
    if (last_err !== 1'b0 || error_code !== 2'b00)
      $display("FAIL soma_status: got err %b code %b want 0 00", last_err, error_code);
    else pass_cnt++;
  endtask

  task automatic test_unary;
    int rb, wb, bz;
    logic [AW-1:0] ea;
    logic [199:0] ed;
    rb = rd_log.size(); wb = wr_addr_log.size(); bz = b_nonzero;
    alu_delay = 1;
    exp_addr_q.push_back(8'h20); exp_data_q.push_back({25{8'hFB}});
    run_cmd(4'd9, 8'h05, 8'h77, 8'h20, 8'h03);
    total_cnt++;
    if (last_to || last_lat != 5) $display("FAIL unary_latency: got %0d (timeout %0b) want 5", last_lat, last_to);
    else pass_cnt++;
    total_cnt++;
    if (rd_log.size() - rb != 1 || rd_log[rb] !== 8'h05)
      $display("FAIL unary_reads: got %0d reads want 1 at 05", rd_log.size() - rb);
    else pass_cnt++;
    total_cnt++;
    if (b_nonzero != bz) $display("FAIL unary_b_zero: got %0d nonzero cycles want 0", b_nonzero - bz);
    else pass_cnt++;
    total_cnt++;
    ea = exp_addr_q.pop_front(); ed = exp_data_q.pop_front();
    if (wr_addr_log.size() - wb != 1 || wr_addr_log[wb] !== ea || wr_data_log[wb] !== ed)
      $display("FAIL unary_write: got %0d writes want 1 at %h data %h", wr_addr_log.size() - wb, ea, ed);
    else pass_cnt++;
  endtask

  task automatic test_illegal;
    logic [3:0] ops [4] = '{4'h0, 4'hF, 4'h2, 4'hD};
    int rb, wb, sb;
    for (int k = 0; k < 4; k++) begin
      rb = rd_log.size(); wb = wr_addr_log.size(); sb = start_cyc;
      run_cmd(ops[k], 8'h01, 8'h02, 8'h30, 8'h00);
      total_cnt++;
      if (last_to || last_lat != 0)
        $display("FAIL illegal_latency op %h: got %0d (timeout %0b) want 0", ops[k], last_lat, last_to);
      else pass_cnt++;
      total_cnt++;
      if (last_err !== 1'b1 || error_code !== 2'b01)
        $display("FAIL illegal_status op %h: got err %b code %b want 1 01", ops[k], last_err, error_code);
      else pass_cnt++;
      total_cnt++;
      if (rd_log.size() != rb || wr_addr_log.size() != wb || start_cyc != sb)
        $display("FAIL illegal_quiet op %h: got rd %0d wr %0d start %0d want 0 0 0", ops[k],
                 rd_log.size() - rb, wr_addr_log.size() - wb, start_cyc - sb);
      else pass_cnt++;
    end
    repeat (4) @(negedge clk);
    total_cnt++;
    if (error_code !== 2'b01 || cmd_done !== 1'b0)
      $display("FAIL illegal_hold: got code %b done %b want 01 0", error_code, cmd_done);
    else pass_cnt++;
  endtask

  task automatic test_bounds;
    int wb;
    logic [AW-1:0] ea;
    logic [199:0] ed;
    wb = wr_addr_log.size();
    alu_delay = 0;
    exp_addr_q.push_back(8'h21); exp_data_q.push_back({25{8'hFF}});
    run_cmd(4'd12, 8'h06, 8'h00, 8'h21, 8'h00);
    total_cnt++;
    if (last_to || last_lat != 5 || error_code !== 2'b00)
      $display("FAIL bound_op12: got lat %0d code %b want 5 00", last_lat, error_code);
    else pass_cnt++;
    total_cnt++;
    ea = exp_addr_q.pop_front(); ed = exp_data_q.pop_front();
    if (wr_addr_log.size() - wb != 1 || wr_addr_log[wb] !== ea || wr_data_log[wb] !== ed)
      $display("FAIL bound_write: got %0d writes want 1 at %h data %h", wr_addr_log.size() - wb, ea, ed);
    else pass_cnt++;
    alu_delay = 1;
  endtask

  task automatic test_back_to_back;
    int wb, sb, ub, swb, d1;
    logic [AW-1:0] ea;
    logic [199:0] ed;
    wb = wr_addr_log.size(); sb = start_cyc; ub = unstable_cnt; swb = start_at_wr;
    alu_delay = 40;
    exp_addr_q.push_back(8'h30); exp_data_q.push_back({25{8'h05}});
    run_cmd(4'd4, 8'h07, 8'h08, 8'h30, 8'h5A);
    d1 = last_done_cyc;
    total_cnt++;
    if (last_to || last_lat != 45) $display("FAIL multi_latency: got %0d (timeout %0b) want 45", last_lat, last_to);
    else pass_cnt++;
    total_cnt++;
    if (start_cyc - sb != 41) $display("FAIL multi_start_len: got %0d want 41", start_cyc - sb);
    else pass_cnt++;
    total_cnt++;
    if (unstable_cnt != ub || start_at_wr != swb)
      $display("FAIL multi_stable: got unstable %0d start_in_wr %0d want 0 0", unstable_cnt - ub, start_at_wr - swb);
    else pass_cnt++;
    total_cnt++;
    ea = exp_addr_q.pop_front(); ed = exp_data_q.pop_front();
    if (wr_addr_log.size() - wb != 1 || wr_addr_log[wb] !== ea || wr_data_log[wb] !== ed)
      $display("FAIL multi_write: got %0d writes want 1 at %h data %h", wr_addr_log.size() - wb, ea, ed);
    else pass_cnt++;
    wb = wr_addr_log.size();
    alu_delay = 1;
    exp_addr_q.push_back(8'h11); exp_data_q.push_back({25{8'h05}});
    run_cmd(4'd3, 8'h01, 8'h02, 8'h11, 8'h00);
    total_cnt++;
    if (last_acc_cyc != d1 + 1) $display("FAIL b2b_accept: got cycle %0d want %0d", last_acc_cyc, d1 + 1);
    else pass_cnt++;
    total_cnt++;
    ea = exp_addr_q.pop_front(); ed = exp_data_q.pop_front();
    if (last_to || last_lat != 6 || wr_addr_log.size() - wb != 1 || wr_addr_log[wb] !== ea || wr_data_log[wb] !== ed)
      $display("FAIL b2b_write: got lat %0d writes %0d want 6 1 at %h", last_lat, wr_addr_log.size() - wb, ea);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    int wb, n;
    wb = wr_addr_log.size();
    alu_delay = 1000;
    @(negedge clk);
    instr_valid = 1'b1; instr_opcode = 4'd3; instr_addr_a = 8'h01;
    instr_addr_b = 8'h02; instr_addr_r = 8'h40; instr_scalar = 8'h00;
    @(negedge clk);
    instr_valid = 1'b0;
    n = 0;
    while (!alu_start && n < 20) begin @(negedge clk); n++; end
    total_cnt++;
    if (alu_start !== 1'b1) $display("FAIL rstmid_exec: got alu_start %b want 1", alu_start);
    else pass_cnt++;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total_cnt++;
    if ({alu_start, busy, instr_ready} !== 3'b001)
      $display("FAIL rstmid_state: got start/busy/ready %b want 001", {alu_start, busy, instr_ready});
    else pass_cnt++;
    rst = 1'b0;
    alu_delay = 1;
    repeat (50) @(negedge clk);
    total_cnt++;
    if (wr_addr_log.size() != wb) $display("FAIL rstmid_nowrite: got %0d writes want 0", wr_addr_log.size() - wb);
    else pass_cnt++;
  endtask

`ifdef ALU_TIMEOUT_EN
  task automatic test_timeout;
    int wb, sb;
    wb = wr_addr_log.size(); sb = start_cyc;
    alu_delay = 10000;
    run_cmd(4'd3, 8'h01, 8'h02, 8'h41, 8'h00);
    total_cnt++;
    if (last_to || last_lat != 19 || start_cyc - sb != 16)
      $display("FAIL timeout_len: got lat %0d start %0d want 19 16", last_lat, start_cyc - sb);
    else pass_cnt++;
    total_cnt++;
    if (last_err !== 1'b1 || error_code !== 2'b10 || wr_addr_log.size() != wb)
      $display("FAIL timeout_status: got err %b code %b writes %0d want 1 10 0", last_err, error_code,
               wr_addr_log.size() - wb);
    else pass_cnt++;
    alu_delay = 1;
  endtask
`endif

  task automatic test_strobes;
    total_cnt++;
    if (both_cnt != 0) $display("FAIL strobe_overlap: got %0d cycles want 0", both_cnt);
    else pass_cnt++;
    total_cnt++;
    if (exp_addr_q.size() != 0) $display("FAIL scoreboard_left: got %0d want 0", exp_addr_q.size());
    else pass_cnt++;
  endtask

  initial begin
    mem[8'h01] = {25{8'h02}};
    mem[8'h02] = {25{8'h03}};
    mem[8'h05] = {25{8'h05}};
    mem[8'h06] = {25{8'h01}};
    mem[8'h07] = {25{8'h09}};
    mem[8'h08] = {25{8'h04}};
    test_reset();
    test_soma();
    test_unary();
    test_illegal();
    test_bounds();
    test_back_to_back();
    test_reset_mid();
`ifdef ALU_TIMEOUT_EN
    test_timeout();
`endif
    test_strobes();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
